// File: rtl/sram_req_arbiter_pkg.sv
// Shared owner encoding, SRAM-like size codes and the request bundle for the arbiter.
package sram_req_arbiter_pkg;

  typedef logic owner_t;
  localparam owner_t OWNER_INST = 1'b0;
  localparam owner_t OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order owner tracker: 1-bit FIFO, head visible combinationally, one-cycle push-to-head.
// Push is ignored when full and pop when empty; the caller gates both.
module owner_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  owner_t                   push_dat,
  input  logic                     pop,
  output owner_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Inst/data to one SRAM-like port arbiter: zero-latency grant and addr_ok, responses routed in order.
// Backpressure: mem_addr_ok low locks the grant; a full tracker holds mem_req low.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int MAX_STARVE  = 3
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           inst_req,
  input  logic                           inst_wr,
  input  logic [1:0]                     inst_size,
  input  logic [31:0]                    inst_addr,
  input  logic [3:0]                     inst_wstrb,
  input  logic [31:0]                    inst_wdata,
  output logic                           inst_addr_ok,
  output logic                           inst_data_ok,
  output logic [31:0]                    inst_rdata,
  input  logic                           data_req,
  input  logic                           data_wr,
  input  logic [1:0]                     data_size,
  input  logic [31:0]                    data_addr,
  input  logic [3:0]                     data_wstrb,
  input  logic [31:0]                    data_wdata,
  output logic                           data_addr_ok,
  output logic                           data_data_ok,
  output logic [31:0]                    data_rdata,
  output logic                           mem_req,
  output logic                           mem_wr,
  output logic [1:0]                     mem_size,
  output logic [31:0]                    mem_addr,
  output logic [3:0]                     mem_wstrb,
  output logic [31:0]                    mem_wdata,
  input  logic                           mem_addr_ok,
  input  logic                           mem_data_ok,
  input  logic [31:0]                    mem_rdata,
  output logic [$clog2(OUTSTANDING):0]   outstanding,
  output logic                           err_orphan
);

  localparam int SW = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);

  logic          en_q, en_d;
  logic          lock_q, lock_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;

  sram_req_t inst_r, data_r, sel_r;
  owner_t    sel, head;
  logic      sel_req, accept, pop, fifo_full, fifo_empty;

  assign inst_r = '{wr: inst_wr, size: inst_size, addr: inst_addr, wstrb: inst_wstrb, wdata: inst_wdata};
  assign data_r = '{wr: data_wr, size: data_size, addr: data_addr, wstrb: data_wstrb, wdata: data_wdata};

  // Unlocked: data wins unless inst has been passed over MAX_STARVE times in a row.
  always_comb begin
    sel = OWNER_INST;
    if (lock_q) begin
      sel = owner_q;
    end else if (data_req && !(inst_req && starve_q == STARVE_LIM)) begin
      sel = OWNER_DATA;
    end
    sel_req = (sel == OWNER_DATA) ? data_req : inst_req;
    sel_r   = (sel == OWNER_DATA) ? data_r : inst_r;
  end

  // en_q keeps the handshakes quiet for the first cycle after reset release.
  assign mem_req      = en_q && !fifo_full && sel_req;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (sel == OWNER_INST);
  assign data_addr_ok = accept && (sel == OWNER_DATA);

  assign mem_wr    = sel_r.wr;
  assign mem_size  = sel_r.size;
  assign mem_addr  = sel_r.addr;
  assign mem_wstrb = sel_r.wstrb;
  assign mem_wdata = sel_r.wdata;

  assign pop          = mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (head == OWNER_INST);
  assign data_data_ok = pop && (head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_orphan   = err_q;

  always_comb begin
    en_d     = 1'b1;
    lock_d   = lock_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    err_d    = err_q || (mem_data_ok && fifo_empty);
    if (accept) begin
      lock_d = 1'b0;
    end else if (mem_req) begin
      lock_d  = 1'b1;
      owner_d = sel;
    end
    if (!inst_req || (accept && sel == OWNER_INST)) begin
      starve_d = '0;
    end else if (accept && starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      en_q     <= 1'b0;
      lock_q   <= 1'b0;
      owner_q  <= OWNER_INST;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (accept),
    .push_dat (sel),
    .pop      (pop),
    .head     (head),
    .count    (outstanding),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter with a queue-based reference model checked every cycle.
module tb_sram_req_arbiter;
  import sram_req_arbiter_pkg::*;

  localparam int OUTSTANDING = 4;
  localparam int MAX_STARVE  = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [$clog2(OUTSTANDING):0] outstanding;
  logic        err_orphan;

  int checks = 0;
  int passed = 0;

  // Reference model state
  bit          mq[$];
  int          m_starve;
  bit          m_lock, m_lock_own, m_err, m_en;
  bit          acc_log[$];
  bit          rsp_own[$];
  logic [31:0] rsp_dat[$];

  always #5 aclk = ~aclk;

  sram_req_arbiter #(.OUTSTANDING(OUTSTANDING), .MAX_STARVE(MAX_STARVE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int count_own(input bit o);
    int n = 0;
    foreach (rsp_own[i]) if (rsp_own[i] == o) n++;
    return n;
  endfunction

  // Compare DUT against the model mid-cycle, then advance the model as the next edge would.
  always @(negedge aclk) begin
    bit full, sd, ereq, eacc, epop, eown, was_empty;
    if (!aresetn) begin
      chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_orphan", err_orphan, 0);
      mq.delete();
      m_starve = 0; m_lock = 0; m_lock_own = 0; m_err = 0; m_en = 0;
    end else begin
      full      = (mq.size() == OUTSTANDING);
      was_empty = (mq.size() == 0);
      sd   = m_lock ? m_lock_own : (data_req && !(inst_req && m_starve == MAX_STARVE));
      ereq = m_en && !full && (m_lock ? (m_lock_own ? data_req : inst_req) : (inst_req || data_req));
      eacc = ereq && mem_addr_ok;
      epop = m_en && mem_data_ok && !was_empty;
      eown = epop ? mq[0] : 1'b0;
      chk("mem_req", mem_req, ereq);
      chk("inst_addr_ok", inst_addr_ok, eacc && !sd);
      chk("data_addr_ok", data_addr_ok, eacc && sd);
      chk("inst_data_ok", inst_data_ok, epop && !eown);
      chk("data_data_ok", data_data_ok, epop && eown);
      chk("outstanding", outstanding, mq.size());
      chk("err_orphan", err_orphan, m_err);
      if (ereq) begin
        chk("mem_addr", mem_addr, sd ? data_addr : inst_addr);
        chk("mem_ctl", {mem_wr, mem_size, mem_wstrb},
            sd ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
        chk("mem_wdata", mem_wdata, sd ? data_wdata : inst_wdata);
      end
      if (epop) begin
        chk("rdata", eown ? data_rdata : inst_rdata, mem_rdata);
        rsp_own.push_back(eown);
        rsp_dat.push_back(mem_rdata);
        void'(mq.pop_front());
      end
      if (eacc) begin
        mq.push_back(sd);
        acc_log.push_back(sd);
        m_lock = 0;
        if (!sd) m_starve = 0;
        else if (inst_req && m_starve < MAX_STARVE) m_starve++;
      end else if (ereq) begin
        m_lock = 1;
        m_lock_own = sd;
      end
      if (!inst_req) m_starve = 0;
      if (mem_data_ok && was_empty) m_err = 1;
      m_en = 1;
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic clear_logs();
    acc_log.delete(); rsp_own.delete(); rsp_dat.delete();
  endtask

  bit exp_order[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    aresetn = 0;
    idle();
    inst_wr = 0; inst_size = SIZE_W; inst_addr = 0; inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_wr = 1; data_size = SIZE_W; data_addr = 0; data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF;
    mem_rdata = 0;
    repeat (3) cyc();
    aresetn = 1;
    cyc(); cyc();

    // Inst-only reads
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      inst_req = (k < 4); inst_addr = 32'h1C00_0000 + 32'(4 * k);
      mem_addr_ok = 1; mem_data_ok = (k >= 2); mem_rdata = 32'h1C00_0000;
      cyc();
    end
    idle(); cyc();
    chk("t1_inst_rsp", count_own(0), 4);
    chk("t1_data_rsp", count_own(1), 0);
    foreach (rsp_dat[i]) chk("t1_rdata", rsp_dat[i], 32'h1C00_0000);

    // Both requesting every cycle: starvation guard
    clear_logs();
    inst_addr = 32'h2000; data_addr = 32'h3000;
    for (int k = 0; k < 8; k++) begin
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = (k >= 1); mem_rdata = 32'(k);
      cyc();
    end
    idle(); mem_data_ok = 1; cyc();
    idle(); cyc();
    chk("t2_accepts", acc_log.size(), 8);
    if (acc_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("t2_order", acc_log[i], exp_order[i]);

    // Lock holds inst while data arrives
    clear_logs();
    inst_req = 1; inst_addr = 32'h100; cyc();
    data_req = 1; data_addr = 32'h200; cyc();
    #1 chk("t3_locked_addr", mem_addr, 32'h100);
    cyc();
    mem_addr_ok = 1;
    #1 chk("t3_inst_first", {inst_addr_ok, data_addr_ok}, 2'b10);
    cyc();
    inst_req = 0;
    #1 chk("t3_data_second", {data_addr_ok, mem_addr}, {1'b1, 32'h200});
    cyc();
    idle(); mem_data_ok = 1; cyc(); cyc();
    idle(); cyc();
    chk("t3_order", {acc_log.size() == 2, acc_log.size() == 2 ? {acc_log[0], acc_log[1]} : 2'b11}, 3'b101);

    // Fill the tracker
    inst_req = 1; inst_addr = 32'h400; mem_addr_ok = 1; cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h500; cyc(); cyc(); cyc();
    #1 chk("t4_full_cnt", outstanding, 4);
    chk("t4_full_req", mem_req, 0);
    cyc();
    mem_data_ok = 1; mem_rdata = 32'h55;
    #1 chk("t4_pop_stall", mem_req, 0);
    chk("t4_pop_oldest", {inst_data_ok, data_data_ok}, 2'b10);
    cyc();
    mem_data_ok = 0;
    #1 chk("t4_next_accept", {data_addr_ok, outstanding}, {1'b1, 3'd3});
    cyc();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; repeat (4) cyc();
    idle(); cyc();
    chk("t4_drained", outstanding, 0);

    // Interleaved I,D,I then three responses
    clear_logs();
    inst_req = 1; inst_addr = 32'h600; mem_addr_ok = 1; cyc();
    inst_req = 0; data_req = 1; data_addr = 32'h700; cyc();
    data_req = 0; inst_req = 1; inst_addr = 32'h604; cyc();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    mem_rdata = 32'hA; cyc();
    mem_rdata = 32'hB; cyc();
    mem_rdata = 32'hC; cyc();
    idle(); cyc();
    chk("t5_rsp_cnt", rsp_own.size(), 3);
    if (rsp_own.size() == 3) begin
      chk("t5_rsp0", {rsp_own[0], rsp_dat[0]}, {1'b0, 32'hA});
      chk("t5_rsp1", {rsp_own[1], rsp_dat[1]}, {1'b1, 32'hB});
      chk("t5_rsp2", {rsp_own[2], rsp_dat[2]}, {1'b0, 32'hC});
    end

    // Orphan response and mid-operation reset
    mem_data_ok = 1; mem_rdata = 32'hDEAD;
    #1 chk("t6_orphan_dropped", {inst_data_ok, data_data_ok}, 2'b00);
    cyc();
    mem_data_ok = 0;
    #1 chk("t6_err_set", err_orphan, 1);
    inst_req = 1; inst_addr = 32'h800; mem_addr_ok = 1; cyc(); cyc();
    idle();
    #1 chk("t6_two_out", outstanding, 2);
    cyc();
    aresetn = 0;
    #1 chk("t6_rst_err", err_orphan, 0);
    chk("t6_rst_cnt", outstanding, 0);
    cyc();
    aresetn = 1; cyc(); cyc();
    mem_data_ok = 1; mem_rdata = 32'h77;
    #1 chk("t6_late_dropped", {inst_data_ok, data_data_ok}, 2'b00);
    cyc();
    mem_data_ok = 0;
    #1 chk("t6_err_again", err_orphan, 1);
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
